reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised integer register file for the RISC-V core, with two combinational read ports and one write port.
- Adds a per-register pending scoreboard: set when an instruction issues to rd, cleared at writeback.
- Adds a sequential clear engine that zeroes all storage one entry per cycle after reset or on request.
- Sits between decode/issue (reads, pending checks) and writeback.

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; register count NREGS = 2**AW.
- ZERO_REG, 1, when 1 entry 0 is hardwired: reads 0, never writes, never pending.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr_req  in  1  pulse to start a clear sweep; sampled only when ready=1.
- ready  out  1  high when the clear engine is idle and the block accepts writes/issues.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_data  out  XLEN  read port 2 data, combinational.
- rs1_pend  out  1  pending bit of rs1_addr, combinational.
- rs2_pend  out  1  pending bit of rs2_addr, combinational.
- RegWrite  in  1  writeback enable.
- rd_addr  in  AW  writeback address.
- rd_data  in  XLEN  writeback data.
- iss_valid  in  1  issue strobe: marks iss_rd pending.
- iss_rd  in  AW  destination of the issuing instruction.

Behaviour:
- Reset (rst_n low, async): FSM=CLEAR, sweep counter=0, all pending bits=0, ready=0. Storage is not reset directly; the sweep clears it.
- FSM state CLEAR: each rising edge writes 0 to entry[cnt], then cnt+1.
  - Edge k after rst_n release (k=1..NREGS) clears entry k-1.
  - The edge that clears entry NREGS-1 moves FSM to IDLE; ready=1 from that edge on.
  - RegWrite, iss_valid and clr_req are ignored.
  - rs*_data and rs*_pend read 0.
- FSM state IDLE: ready=1.
  - clr_req=1 at an edge: FSM to CLEAR, cnt=0, all pending bits cleared on that same edge.
  - A write or issue in that same cycle is dropped.
- Write (IDLE): at an edge with RegWrite=1 and not (ZERO_REG and rd_addr==0): entry[rd_addr]<=rd_data and pending[rd_addr]<=0.
- Issue (IDLE): at an edge with iss_valid=1 and not (ZERO_REG and iss_rd==0): pending[iss_rd]<=1.
- Issue and write to the same address at the same edge: data is written, pending ends 1 (set wins, new producer).
- Reads: asynchronous from storage.
  - If ZERO_REG and addr==0: data=0, pend=0.
  - Otherwise data=entry[addr], pend=pending[addr] (subject to the optional bypass).
- With ZERO_REG=0, entry 0 is an ordinary register.
- Reset asserted mid-sweep restarts the sweep from entry 0. Reset asserted mid-operation discards all pending bits.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in IDLE, if RegWrite=1 and rd_addr==rsX_addr (excluding hardwired zero), then rsX_data=rd_data and rsX_pend=0 in the same cycle (write-through).
- Undefined: read ports show the old value and old pending bit until the edge after the write.

Test Plan:
- Reset sweep: rst_n low, preload no writes, release -> ready=0 for exactly 32 edges, rises after edge 32; all rs*_data=0.
- Write/read: write x5=0xDEADBEEF, next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF. Write x0=0x1234 with ZERO_REG=1 -> rs2_addr=0 reads 0.
- Scoreboard: issue iss_rd=7 -> rs1_pend=1 for addr 7. Write x7=0x55 -> pend=0, data=0x55. Issue and write x9 at the same edge -> pend(9)=1, data(9)=written value.
- Bypass: RegWrite=1, rd_addr=3, rd_data=0xA5A5A5A5, rs2_addr=3 in the same cycle:
  - Macro defined -> rs2_data=0xA5A5A5A5, rs2_pend=0.
  - Undefined -> old value until the next edge.
- clr_req: registers x1..x4 nonzero, x2 pending, pulse clr_req -> ready=0 for 32 edges; a write during the sweep is ignored; afterwards all data=0 and pend=0.
- Reset mid-sweep: assert rst_n low at sweep edge 10, release -> ready returns only after a full 32-edge sweep.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with two combinational read ports, one
// write port, a per-register pending scoreboard and a sequential clear engine
// that zeroes one entry per cycle after reset or on request.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through to the read ports.
`timescale 1ns/1ps
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_req,
    output logic            ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_pend,
    output logic            rs2_pend,
    input  logic            RegWrite,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd
);
    localparam int NREGS = 2**AW;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     cnt, cnt_nx;
    logic [NREGS-1:0]  pend;
    logic [XLEN-1:0]   mem [NREGS];
    logic              we, iss;

    assign ready = (state == S_IDLE);

    // A clr_req in the same cycle drops both the write and the issue.
    assign we  = ready && !clr_req && RegWrite &&
                 !((ZERO_REG != 0) && (rd_addr == '0));
    assign iss = ready && !clr_req && iss_valid &&
                 !((ZERO_REG != 0) && (iss_rd == '0));

    // State and sweep counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state: sweep through every entry, then idle until a clear request.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_CLEAR: begin
                cnt_nx = cnt + AW'(1);
                if (cnt == AW'(NREGS - 1)) state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (clr_req) begin
                    state_nx = S_CLEAR;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = S_CLEAR;
        endcase
    end

    // Storage has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR)
            mem[cnt] <= '0;
        else if (we)
            mem[rd_addr] <= rd_data;
    end

    // Scoreboard: writeback clears, issue sets; issue is applied last so a
    // same-address issue and write leaves the entry pending (new producer).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (ready && clr_req) begin
            pend <= '0;
        end else begin
            if (we)  pend[rd_addr] <= 1'b0;
            if (iss) pend[iss_rd]  <= 1'b1;
        end
    end

    logic [1:0][AW-1:0]   ra;
    logic [1:0][XLEN-1:0] rdat;
    logic [1:0]           rpnd;

    assign ra       = {rs2_addr, rs1_addr};
    assign rs1_data = rdat[0];
    assign rs2_data = rdat[1];
    assign rs1_pend = rpnd[0];
    assign rs2_pend = rpnd[1];

    // Combinational read ports; everything reads 0 while the sweep runs.
    always_comb begin
        rdat = '0;
        rpnd = '0;
        for (int p = 0; p < 2; p++) begin
            if (ready && !((ZERO_REG != 0) && (ra[p] == '0))) begin
`ifdef REGFILE_BYPASS_EN
                if (we && (rd_addr == ra[p])) begin
                    rdat[p] = rd_data;
                    rpnd[p] = 1'b0;
                end else begin
                    rdat[p] = mem[ra[p]];
                    rpnd[p] = pend[ra[p]];
                end
`else
                rdat[p] = mem[ra[p]];
                rpnd[p] = pend[ra[p]];
`endif
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector table plus hand-written sequences for the
// reset sweep, clear request and reset during a sweep.
`timescale 1ns/1ps
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_req = 1'b0;
    logic        ready;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_pend, rs2_pend;
    logic        RegWrite = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] rd_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;

    int total = 0;
    int bad   = 0;

    reg_file_sb #(.XLEN(32), .AW(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
        .RegWrite(RegWrite), .rd_addr(rd_addr), .rd_data(rd_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] d1;
        logic        p1;
        logic [31:0] d2;
        logic        p2;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Count 32 sweep edges: ready must stay low until the 32nd.
    task automatic sweep_check(input string nm);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_ready_e%0d", nm, k), {31'b0, ready}, (k == 32) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic all_zero(input string nm);
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            chk($sformatf("%s_d_x%0d", nm, a), rs1_data, 32'h0);
            chk($sformatf("%s_p_x%0d", nm, a), {31'b0, rs1_pend | rs2_pend}, 32'h0);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ir);
        @(negedge clk);
        RegWrite = we; rd_addr = rd; rd_data = wd; iss_valid = iv; iss_rd = ir;
    endtask

    initial begin
        //              we  rd     wd            iv  ir     a1     a2     d1            p1  d2            p2
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[1] = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd5, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd0, 32'h0,        1'b1, 32'h0,        1'b0};
        tbl[4] = '{1'b1, 5'd7, 32'h00000055, 1'b0, 5'd0, 5'd5, 5'd1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[5] = '{1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 5'd7, 5'd5, 32'h00000055, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd9, 5'd7, 32'h00000099, 1'b1, 32'h00000055, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd3, 5'd0, 32'h0,        1'b1, 32'h0,        1'b0};
`ifdef REGFILE_BYPASS_EN
        tbl[8] = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd9, 5'd3, 32'h00000099, 1'b1, 32'hA5A5A5A5, 1'b0};
`else
        tbl[8] = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd9, 5'd3, 32'h00000099, 1'b1, 32'h0,        1'b1};
`endif
        tbl[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        1'b0, 32'hA5A5A5A5, 1'b0};

        // Reset and initial sweep.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_rs1", rs1_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check("init");
        all_zero("init");

        // Vector table: check reads in the pre-edge half, edge then commits.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RegWrite = tbl[i].we; rd_addr = tbl[i].rd; rd_data = tbl[i].wd;
            iss_valid = tbl[i].iv; iss_rd = tbl[i].ir;
            rs1_addr = tbl[i].a1; rs2_addr = tbl[i].a2;
            #1;
            chk($sformatf("v%0d_rs1_data", i), rs1_data, tbl[i].d1);
            chk($sformatf("v%0d_rs1_pend", i), {31'b0, rs1_pend}, {31'b0, tbl[i].p1});
            chk($sformatf("v%0d_rs2_data", i), rs2_data, tbl[i].d2);
            chk($sformatf("v%0d_rs2_pend", i), {31'b0, rs2_pend}, {31'b0, tbl[i].p2});
        end

        // Clear request: x1..x4 nonzero, x2 pending.
        drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0);
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd2);
        drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
        drive(1'b0, 5'd0, 32'h0,  1'b0, 5'd0);
        rs1_addr = 5'd2; rs2_addr = 5'd4;
        #1;
        chk("pre_clr_x2_pend", {31'b0, rs1_pend}, 32'h1);
        chk("pre_clr_x4_data", rs2_data, 32'h44);
        // Write in the clr_req cycle and during the sweep must both be dropped.
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        rd_addr = 5'd8; rd_data = 32'h88;
        chk("clr_ready_low", {31'b0, ready}, 32'h0);
        sweep_check("clr");
        RegWrite = 1'b0;
        all_zero("clr");

        // Reset in the middle of a clear sweep restarts it from entry 0.
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
